// File: rtl/sram_stream_client_pkg.sv
// ---------------------------------------------------------------------------
// sram_stream_client_pkg : shared constants, state type and helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sram_stream_client_pkg;

  localparam int SRAM_WORD    = 256;
  localparam int HEADER_BIT   = 4;
  localparam int T_PER_WORD   = 7;
  localparam int TSIZE_W      = 12;
  localparam int READ_LATENCY = 3;
  localparam int REQ_GAP      = 4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    INIT_PULSE = 3'd1,
    INIT_WAIT  = 3'd2,
    RUN        = 3'd3,
    DRAIN      = 3'd4
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_stream_client_if.sv
// ---------------------------------------------------------------------------
// sram_stream_client_if : SRAM controller and PE stream signals of the client
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sram_stream_client_if #(
  parameter int SRAM_WORD = sram_stream_client_pkg::SRAM_WORD,
  parameter int TSIZE_W   = sram_stream_client_pkg::TSIZE_W
);

  logic                 i_start;
  logic                 o_init;
  logic                 i_busy;
  logic [TSIZE_W-1:0]   i_T_size;
  logic                 o_PE_request;
  logic [SRAM_WORD-1:0] i_request_data;
  logic                 o_PE_send;
  logic [SRAM_WORD-1:0] o_send_data;
  logic                 o_word_valid;
  logic                 i_word_ready;
  logic [SRAM_WORD-1:0] o_word;
  logic                 i_wb_valid;
  logic                 o_wb_ready;
  logic [SRAM_WORD-1:0] i_wb_word;
  logic                 o_pass_done;

  modport slave (
    input  i_start, i_busy, i_T_size, i_request_data, i_word_ready, i_wb_valid, i_wb_word,
    output o_init, o_PE_request, o_PE_send, o_send_data, o_word_valid, o_word, o_wb_ready,
           o_pass_done
  );

  modport master (
    output i_start, i_busy, i_T_size, i_request_data, i_word_ready, i_wb_valid, i_wb_word,
    input  o_init, o_PE_request, o_PE_send, o_send_data, o_word_valid, o_word, o_wb_ready,
           o_pass_done
  );

endinterface

`default_nettype wire

// File: rtl/sram_stream_client_word_fifo2.sv
// ---------------------------------------------------------------------------
// word_fifo2 : two-entry word FIFO, head exposed combinationally
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module word_fifo2 #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             w_push;
  logic             w_pop;

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_pop  = pop_i && (count_q != 2'd0);
  assign w_push = push_i && ((count_q != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/sram_stream_client.sv
// ---------------------------------------------------------------------------
// sram_stream_client : init + one read/writeback pass over a T-sized SRAM image
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_stream_client #(
  parameter int SRAM_WORD  = sram_stream_client_pkg::SRAM_WORD,
  parameter int TSIZE_W    = sram_stream_client_pkg::TSIZE_W,
  parameter int T_PER_WORD = sram_stream_client_pkg::T_PER_WORD
) (
  input  logic                       clk,
  input  logic                       rst_n,
  sram_stream_client_if.slave        bus
);

  import sram_stream_client_pkg::*;

  if (SRAM_WORD <= HEADER_BIT || READ_LATENCY < 3 || REQ_GAP != READ_LATENCY + 1 ||
      T_PER_WORD < 1) begin : g_bad_params
    $error("sram_stream_client: unsupported parameter set");
  end

  state_e                  state_q, state_d;
  logic [TSIZE_W-1:0]      total_q, total_d;
  logic [TSIZE_W-1:0]      req_cnt_q, req_cnt_d;
  logic [TSIZE_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic                    busy_seen_q, busy_seen_d;
  logic [READ_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  logic                    defer_q, defer_d;
  logic                    send_q, send_d;
  logic [SRAM_WORD-1:0]    send_data_q, send_data_d;
  logic                    pass_done_q, pass_done_d;

  logic                    w_outstanding;
  logic                    w_capture;
  logic                    w_ret_soon;
  logic                    w_slot_free;
  logic                    w_req_base;
  logic                    w_req_fire;
  logic                    w_wb_ready;
  logic                    w_wb_accept;
  logic                    w_fifo_empty;
  logic [1:0]              w_fifo_cnt;
  logic [SRAM_WORD-1:0]    w_fifo_head;
  logic                    w_pop;

  // rd_pipe_q[k] marks a read issued k+1 cycles ago; the top bit is the capture cycle.
  assign w_outstanding = |rd_pipe_q;
  assign w_capture     = rd_pipe_q[READ_LATENCY-1];
  // A send accepted now goes out next cycle; keep it off capture cycles now+1 and now+2.
  assign w_ret_soon    = rd_pipe_q[READ_LATENCY-2] | rd_pipe_q[READ_LATENCY-3];
  assign w_slot_free   = (w_fifo_cnt == 2'd0) || ((w_fifo_cnt == 2'd1) && !w_outstanding);

  assign w_req_base  = (state_q == RUN) && !bus.i_busy && (req_cnt_q < total_q) &&
                       w_slot_free && !w_outstanding;
  // A request already pushed back by a writeback gets the next slot, so a held
  // writeback stream cannot starve reads.
  assign w_wb_ready  = ((state_q == RUN) || (state_q == DRAIN)) && (wr_cnt_q < total_q) &&
                       !w_ret_soon && !(w_req_base && (send_q || defer_q));
  assign w_wb_accept = bus.i_wb_valid && w_wb_ready;
  assign w_req_fire  = w_req_base && !send_q && !w_wb_accept;
  assign w_pop       = !w_fifo_empty && bus.i_word_ready;

  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    req_cnt_d   = req_cnt_q + TSIZE_W'(w_req_fire);
    wr_cnt_d    = wr_cnt_q + TSIZE_W'(w_wb_accept);
    busy_seen_d = busy_seen_q;
    rd_pipe_d   = {rd_pipe_q[READ_LATENCY-2:0], w_req_fire};
    defer_d     = w_req_base && !w_req_fire;
    send_d      = w_wb_accept;
    send_data_d = w_wb_accept ? bus.i_wb_word : send_data_q;
    pass_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          total_d     = TSIZE_W'(ceil_div(32'(bus.i_T_size), 32'(T_PER_WORD)));
          req_cnt_d   = '0;
          wr_cnt_d    = '0;
          busy_seen_d = 1'b0;
          state_d     = INIT_PULSE;
        end
      end
      INIT_PULSE: begin
        state_d = INIT_WAIT;
      end
      INIT_WAIT: begin
        if (bus.i_busy) begin
          busy_seen_d = 1'b1;
        end
        if (busy_seen_q && !bus.i_busy) begin
          if (total_q == '0) begin
            pass_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (req_cnt_q == total_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (w_fifo_empty && !w_outstanding && !send_q && (wr_cnt_q == total_q)) begin
          pass_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      total_q     <= '0;
      req_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      busy_seen_q <= 1'b0;
      rd_pipe_q   <= '0;
      defer_q     <= 1'b0;
      send_q      <= 1'b0;
      send_data_q <= '0;
      pass_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      req_cnt_q   <= req_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      busy_seen_q <= busy_seen_d;
      rd_pipe_q   <= rd_pipe_d;
      defer_q     <= defer_d;
      send_q      <= send_d;
      send_data_q <= send_data_d;
      pass_done_q <= pass_done_d;
    end
  end

  word_fifo2 #(
    .WIDTH (SRAM_WORD)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_capture),
    .data_i  (bus.i_request_data),
    .pop_i   (w_pop),
    .data_o  (w_fifo_head),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_cnt)
  );

  assign bus.o_init       = (state_q == INIT_PULSE);
  assign bus.o_PE_request = w_req_fire;
  assign bus.o_PE_send    = send_q;
  assign bus.o_send_data  = send_data_q;
  assign bus.o_word_valid = !w_fifo_empty;
  assign bus.o_word       = w_fifo_head;
  assign bus.o_wb_ready   = w_wb_ready;
  assign bus.o_pass_done  = pass_done_q;

endmodule

`default_nettype wire

// File: doc/sram_stream_client.md
SRAM_STREAM_CLIENT -- requirements
Module: sram_stream_client

Interface
REQ-001 Parameter SRAM_WORD, default 256, SRAM word width in bits.
REQ-002 Parameter TSIZE_W, default 12, width of T-size count.
REQ-003 Parameter T_PER_WORD, default 7, T symbols packed per SRAM word.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_start  in  1  pulse; begin init plus one read pass.
REQ-007 o_init  out  1  one-cycle init pulse to SRAM controller.
REQ-008 i_busy  in  1  SRAM controller busy.
REQ-009 i_T_size  in  TSIZE_W  T symbols stored; sampled on i_start.
REQ-010 o_PE_request  out  1  one-cycle word read request to controller.
REQ-011 i_request_data  in  SRAM_WORD  read word returned by controller.
REQ-012 o_PE_send  out  1  one-cycle word write to controller.
REQ-013 o_send_data  out  SRAM_WORD  write word; valid with o_PE_send.
REQ-014 o_word_valid / i_word_ready / o_word[SRAM_WORD]  out/in/out  read stream to PE array.
REQ-015 i_wb_valid / o_wb_ready / i_wb_word[SRAM_WORD]  in/out/in  writeback stream from PE array.
REQ-016 o_pass_done  out  1  one-cycle pulse; pass complete.

Function
REQ-017 States SHALL be IDLE, INIT_PULSE, INIT_WAIT, RUN, DRAIN.
REQ-018 IDLE: i_start -> INIT_PULSE; latch words_total = ceil(i_T_size/T_PER_WORD); i_start ignored outside IDLE.
REQ-019 INIT_PULSE: o_init=1 one cycle -> INIT_WAIT.
REQ-020 INIT_WAIT: leave only after i_busy seen high then low; words_total=0 -> pulse o_pass_done, go IDLE; else -> RUN.
REQ-021 Read timing fixed: request at cycle n -> i_request_data captured at cycle n+3 exactly; no valid-detection on data value.
REQ-022 Minimum request spacing 4 cycles; next o_PE_request no earlier than cycle n+4.
REQ-023 At most one read outstanding.
REQ-024 Request issued only when RUN, i_busy=0, requested<words_total, and 2-entry buffer has a free slot counting the outstanding read.
REQ-025 o_PE_request and o_PE_send SHALL never be high in the same cycle; writeback wins; a request deferred by a send retries next eligible cycle.
REQ-026 o_PE_send asserted only when no read return is due in that cycle or the next (sends stay clear of a pending capture).
REQ-027 Read buffer: 2-entry FIFO; o_word = head; pop on o_word_valid & i_word_ready; push and pop same cycle allowed.
REQ-028 o_wb_ready = 1 in RUN/DRAIN when a send is allowed this cycle; accepted word drives o_send_data/o_PE_send next cycle, registered.
REQ-029 Counters requested and written, TSIZE_W bits, no wrap; RUN -> DRAIN when requested==words_total.
REQ-030 DRAIN: wait FIFO empty, no read outstanding, written==words_total -> pulse o_pass_done, go IDLE.
REQ-031 Writebacks beyond words_total SHALL be refused (o_wb_ready=0).

Reset
REQ-032 Reset: state IDLE, counters 0, FIFO empty, outstanding cleared.
REQ-033 All outputs 0 during and after reset.
REQ-034 Reset mid-pass SHALL discard any in-flight return; no spurious push after release.

Structure
REQ-035 SRAM_WORD, HEADER_BIT(4), T_PER_WORD, READ_LATENCY(3), REQ_GAP(4) belong in shared package/include.
REQ-036 The 2-entry FIFO is a sub-module word_fifo2.

Verification
REQ-037 T_size=14 -> one o_init, 2 requests >=4 cycles apart, 2 words out, 2 writebacks, o_pass_done once.
REQ-038 i_word_ready=0 with T_size=35 -> exactly 2 requests issued then stall; release -> remaining 3 fetched in order.
REQ-039 i_wb_valid held high on a request-eligible cycle -> o_PE_send only that cycle, request one cycle later, never both.
REQ-040 Garbage on i_request_data except at n+3 -> only the n+3 word enters FIFO.
REQ-041 rst_n low 1 cycle after o_PE_request -> no FIFO push at n+3, state IDLE, outputs 0.
REQ-042 T_size=0 -> o_init, wait i_busy fall, o_pass_done, zero requests.
